// File: rtl/tribus_pkg.sv
// rtl/tribus_pkg.sv - shared state encoding and default parameters for the tristate bus controller
package tribus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_DEAD = 2'd2
   } tribus_state_t;

   localparam int TRIBUS_NREQ     = 4;
   localparam int TRIBUS_DEAD_CYC = 2;
   localparam int TRIBUS_MAX_HOLD = 16;

   // Counter widths cover the full legal ranges of MAX_HOLD (255) and DEAD_CYC (15).
   localparam int HOLD_W = 8;
   localparam int DEAD_W = 4;

endpackage

// File: rtl/tribus_rr_arb.sv
// rtl/tribus_rr_arb.sv - combinational round-robin pick: first requester at or after ptr wins
module tribus_rr_arb
   import tribus_pkg::*;
#(
   parameter int NREQ = TRIBUS_NREQ,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic            valid
);

   always_comb begin
      int            s;
      logic [PW-1:0] idx;
      grant = '0;
      valid = 1'b0;
      s     = 0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         s = int'(ptr) + i;
         if (s >= NREQ) s = s - NREQ;
         idx = PW'(s);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tribus_ctrl.sv
// rtl/tribus_ctrl.sv - tristate bus ownership FSM with dead time and hold limit
// Optional bus keeper outputs are built when TRIBUS_KEEPER_EN is defined.
module tribus_ctrl
   import tribus_pkg::*;
#(
   parameter int NREQ     = TRIBUS_NREQ,
   parameter int DEAD_CYC = TRIBUS_DEAD_CYC,
   parameter int MAX_HOLD = TRIBUS_MAX_HOLD
) (
   input  logic            CLK,
   input  logic            RN,
   input  logic [NREQ-1:0] REQ,
   output logic [NREQ-1:0] EN,
`ifdef TRIBUS_KEEPER_EN
   input  logic            BUS_IN,
   output logic            KEEP_EN,
   output logic            KEEP_VAL,
`endif
   output logic            BUS_IDLE
);

   localparam int PW = $clog2(NREQ);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYC);

   tribus_state_t     state, state_nx;
   logic [NREQ-1:0]   own_oh, own_oh_nx, en_nx, grant;
   logic              grant_vld;
   logic [PW-1:0]     ptr, ptr_nx, gidx, ptr_after_grant;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
   logic [DEAD_W-1:0] dead_cnt, dead_cnt_nx;
   logic              owner_req, other_req;

   tribus_rr_arb #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req   (REQ),
      .ptr   (ptr),
      .grant (grant),
      .valid (grant_vld)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) gidx = PW'(i);
      end
   end

   assign ptr_after_grant = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
   assign owner_req       = |(REQ & own_oh);
   assign other_req       = |(REQ & ~own_oh);

   always_comb begin
      state_nx    = state;
      own_oh_nx   = own_oh;
      ptr_nx      = ptr;
      hold_cnt_nx = hold_cnt;
      dead_cnt_nx = dead_cnt;
      case (state)
         ST_IDLE: begin
            if (grant_vld) begin
               state_nx    = ST_OWN;
               own_oh_nx   = grant;
               ptr_nx      = ptr_after_grant;
               hold_cnt_nx = HOLD_W'(1);
            end
         end
         ST_OWN: begin
            // Hold limit only bites when someone else is waiting.
            if (!owner_req || (hold_cnt == HOLD_MAX && other_req)) begin
               state_nx    = ST_DEAD;
               hold_cnt_nx = '0;
               dead_cnt_nx = DEAD_W'(1);
            end else if (hold_cnt != HOLD_MAX) begin
               hold_cnt_nx = hold_cnt + HOLD_W'(1);
            end
         end
         ST_DEAD: begin
            if (dead_cnt == DEAD_MAX) begin
               dead_cnt_nx = '0;
               if (grant_vld) begin
                  state_nx    = ST_OWN;
                  own_oh_nx   = grant;
                  ptr_nx      = ptr_after_grant;
                  hold_cnt_nx = HOLD_W'(1);
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               dead_cnt_nx = dead_cnt + DEAD_W'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      en_nx = (state_nx == ST_OWN) ? own_oh_nx : '0;
   end

   // EN and BUS_IDLE are registered from the same next value so they never disagree.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state    <= ST_IDLE;
         own_oh   <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
         dead_cnt <= '0;
         EN       <= '0;
         BUS_IDLE <= 1'b1;
      end else begin
         state    <= state_nx;
         own_oh   <= own_oh_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_cnt_nx;
         dead_cnt <= dead_cnt_nx;
         EN       <= en_nx;
         BUS_IDLE <= ~|en_nx;
      end
   end

`ifdef TRIBUS_KEEPER_EN
   logic owned_once;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         owned_once <= 1'b0;
         KEEP_EN    <= 1'b0;
         KEEP_VAL   <= 1'b0;
      end else begin
         if (state_nx == ST_OWN) owned_once <= 1'b1;
         KEEP_EN <= (state_nx != ST_OWN) && owned_once;
         if (state == ST_OWN) KEEP_VAL <= BUS_IN;
      end
   end
`endif

endmodule

// File: tb/tb_tribus_ctrl.sv
// tb/tb_tribus_ctrl.sv - scoreboard bench for tribus_ctrl; keeper checks built with TRIBUS_KEEPER_EN
module tb_tribus_ctrl;
   import tribus_pkg::*;

   typedef struct packed {
      logic [7:0]    tag;
      logic [3:0]    en;
      logic          idle;
      tribus_state_t st;
      logic          kchk;
      logic          ken;
      logic          kval;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RN;
   logic [3:0] REQ;
   logic [3:0] EN;
   logic       BUS_IDLE;
`ifdef TRIBUS_KEEPER_EN
   logic       BUS_IN;
   logic       KEEP_EN;
   logic       KEEP_VAL;
`endif

   exp_t       exp_q[$];
   int         total = 0;
   int         bad   = 0;
   logic [7:0] cur_tag = 8'd0;

   always #5 CLK = ~CLK;

   tribus_ctrl dut (
      .CLK      (CLK),
      .RN       (RN),
      .REQ      (REQ),
      .EN       (EN),
`ifdef TRIBUS_KEEPER_EN
      .BUS_IN   (BUS_IN),
      .KEEP_EN  (KEEP_EN),
      .KEEP_VAL (KEEP_VAL),
`endif
      .BUS_IDLE (BUS_IDLE)
   );

   task automatic expect_nx(input logic [3:0] en, input logic idle, input tribus_state_t st,
                            input logic kchk, input logic ken, input logic kval);
      exp_t e;
      e.tag  = cur_tag;
      e.en   = en;
      e.idle = idle;
      e.st   = st;
      e.kchk = kchk;
      e.ken  = ken;
      e.kval = kval;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] en, input logic idle, input tribus_state_t st);
      @(negedge CLK);
      REQ = r;
      expect_nx(en, idle, st, 1'b0, 1'b0, 1'b0);
   endtask

`ifdef TRIBUS_KEEPER_EN
   task automatic step_k(input logic [3:0] r, input logic [3:0] en, input logic idle, input tribus_state_t st,
                         input logic ken, input logic kval);
      @(negedge CLK);
      REQ = r;
      expect_nx(en, idle, st, 1'b1, ken, kval);
   endtask
`endif

   task automatic check_idle_now(input string name);
      total++;
      if (EN !== 4'b0000 || BUS_IDLE !== 1'b1 || dut.state !== ST_IDLE) begin
         bad++;
         $display("FAIL %s: EN=%b BUS_IDLE=%b state=%0d, want EN=0000 BUS_IDLE=1 state=0",
                  name, EN, BUS_IDLE, dut.state);
      end
   endtask

   task automatic do_reset;
      @(negedge CLK);
      RN  = 1'b0;
      REQ = 4'b0000;
      #1 check_idle_now("reset_state");
      @(negedge CLK);
      RN = 1'b1;
   endtask

   // Monitor: one-hot guard every cycle, scoreboard pop whenever an expectation is queued.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         total++;
         if ($countones(EN) > 1) begin
            bad++;
            $display("FAIL onehot: EN=%b, want at most one bit set", EN);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (EN !== e.en || BUS_IDLE !== e.idle || dut.state !== e.st) begin
               bad++;
               $display("FAIL t%0d: EN=%b BUS_IDLE=%b state=%0d, want EN=%b BUS_IDLE=%b state=%0d",
                        e.tag, EN, BUS_IDLE, dut.state, e.en, e.idle, e.st);
            end
`ifdef TRIBUS_KEEPER_EN
            if (e.kchk) begin
               total++;
               if (KEEP_EN !== e.ken || KEEP_VAL !== e.kval) begin
                  bad++;
                  $display("FAIL keeper t%0d: KEEP_EN=%b KEEP_VAL=%b, want KEEP_EN=%b KEEP_VAL=%b",
                           e.tag, KEEP_EN, KEEP_VAL, e.ken, e.kval);
               end
            end
`endif
         end
      end
   end

   initial begin
      RN  = 1'b0;
      REQ = 4'b0000;
`ifdef TRIBUS_KEEPER_EN
      BUS_IN = 1'b0;
`endif
      repeat (2) @(negedge CLK);

      // single requester, held past MAX_HOLD with no contention
      cur_tag = 8'd1;
      do_reset;
      repeat (3) step(4'b0000, 4'b0000, 1'b1, ST_IDLE);
      repeat (20) step(4'b0001, 4'b0001, 1'b0, ST_OWN);
      repeat (2) step(4'b0000, 4'b0000, 1'b1, ST_DEAD);
      step(4'b0000, 4'b0000, 1'b1, ST_IDLE);

      // handover 0 -> 1 through exactly two dead cycles
      cur_tag = 8'd2;
      do_reset;
      repeat (4) step(4'b0011, 4'b0001, 1'b0, ST_OWN);
      repeat (2) step(4'b0010, 4'b0000, 1'b1, ST_DEAD);
      repeat (3) step(4'b0010, 4'b0010, 1'b0, ST_OWN);
      repeat (2) step(4'b0000, 4'b0000, 1'b1, ST_DEAD);
      step(4'b0000, 4'b0000, 1'b1, ST_IDLE);

      // full contention: owners 0,1,2,3,0 for 16 cycles each
      cur_tag = 8'd3;
      do_reset;
      for (int o = 0; o < 5; o++) begin
         repeat (16) step(4'b1111, 4'(1 << (o % 4)), 1'b0, ST_OWN);
         if (o < 4) repeat (2) step(4'b1111, 4'b0000, 1'b1, ST_DEAD);
      end
      repeat (2) step(4'b0000, 4'b0000, 1'b1, ST_DEAD);
      step(4'b0000, 4'b0000, 1'b1, ST_IDLE);

      // REQ[2] pulse confined to DEAD is ignored
      cur_tag = 8'd4;
      do_reset;
      repeat (2) step(4'b0001, 4'b0001, 1'b0, ST_OWN);
      step(4'b0000, 4'b0000, 1'b1, ST_DEAD);
      step(4'b0100, 4'b0000, 1'b1, ST_DEAD);
      repeat (2) step(4'b0000, 4'b0000, 1'b1, ST_IDLE);

      // asynchronous reset while driver 2 owns the bus
      cur_tag = 8'd5;
      do_reset;
      repeat (2) step(4'b0100, 4'b0100, 1'b0, ST_OWN);
      @(negedge CLK);
      #1 RN = 1'b0;
      #1 check_idle_now("reset_mid_own");
      @(negedge CLK);
      RN  = 1'b1;
      REQ = 4'b0100;
      expect_nx(4'b0100, 1'b0, ST_OWN, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 1'b1, ST_DEAD);

`ifdef TRIBUS_KEEPER_EN
      // keeper holds the last driven value after release
      cur_tag = 8'd6;
      do_reset;
      BUS_IN = 1'b0;
      step_k(4'b0000, 4'b0000, 1'b1, ST_IDLE, 1'b0, 1'b0);
      BUS_IN = 1'b1;
      repeat (3) step(4'b0001, 4'b0001, 1'b0, ST_OWN);
      step_k(4'b0000, 4'b0000, 1'b1, ST_DEAD, 1'b1, 1'b1);
      BUS_IN = 1'b0;
      step_k(4'b0000, 4'b0000, 1'b1, ST_DEAD, 1'b1, 1'b1);
      repeat (2) step_k(4'b0000, 4'b0000, 1'b1, ST_IDLE, 1'b1, 1'b1);
`endif

      repeat (2) @(negedge CLK);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tribus_ctrl.md
TRIBUS_CTRL -- requirements
Module: tribus_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of tristate drivers sharing one bus line (2..8).
REQ-002 SHALL have parameter DEAD_CYC, default 2, meaning all-drivers-off cycles between owners (1..15).
REQ-003 SHALL have parameter MAX_HOLD, default 16, meaning ownership cycles before forced release under contention (2..255).
REQ-004 SHALL have port CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RN, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port REQ, input, NREQ, meaning level request per driver, held while that driver wants the bus.
REQ-007 SHALL have port EN, output, NREQ, meaning registered tristate enables, one per driver, wired to the drivers' EN pins.
REQ-008 SHALL have port BUS_IDLE, output, 1, meaning registered flag, high when no EN bit is set.

Function
REQ-009 SHALL implement an FSM with states IDLE, OWN and DEAD.
REQ-010 SHALL hold EN at zero in IDLE and DEAD, and at one-hot EN[owner] in OWN.
REQ-011 SHALL never assert more than one EN bit in any cycle.
REQ-012 SHALL move IDLE->OWN on the edge after any REQ bit is sampled high, so EN rises one cycle after REQ.
REQ-013 SHALL choose the owner round-robin, starting at the index after the previous owner; after reset, search starts at index 0.
REQ-014 SHALL latch the owner on entry to OWN; later REQ changes do not alter the owner.
REQ-015 SHALL move OWN->DEAD when REQ[owner] is sampled low, with EN low on the next cycle.
REQ-016 SHALL count hold cycles from entry to OWN, saturating at MAX_HOLD.
REQ-017 SHALL force OWN->DEAD when hold count equals MAX_HOLD and any other REQ bit is high.
REQ-018 SHALL keep ownership indefinitely when there is no contention.
REQ-019 SHALL stay in DEAD exactly DEAD_CYC cycles.
REQ-020 SHALL then go to OWN with a newly arbitrated owner if any REQ bit is high, else to IDLE.
REQ-021 SHALL allow the released owner to win after DEAD only if no other requester is high.
REQ-022 SHALL ignore REQ pulses that rise and fall entirely within DEAD.
REQ-023 SHALL set BUS_IDLE equal to the registered NOR of EN.

Reset
REQ-024 SHALL, while RN is low, force state IDLE, EN=0, BUS_IDLE=1, hold and dead counters to 0, and round-robin pointer to 0, asynchronously.
REQ-025 SHALL, when RN is asserted during OWN, drop EN within the same cycle without any dead-time sequence.
REQ-026 SHALL deassert reset synchronously: first arbitration occurs on the first CLK edge after RN rises.

Configuration
REQ-027 SHALL, with macro TRIBUS_KEEPER_EN defined, add input BUS_IN (1), output KEEP_EN (1) and output KEEP_VAL (1).
REQ-028 SHALL, with TRIBUS_KEEPER_EN defined, capture BUS_IN into KEEP_VAL in every OWN cycle.
REQ-029 SHALL, with TRIBUS_KEEPER_EN defined, drive KEEP_EN high in IDLE/DEAD after the first ownership since reset, and low otherwise.
REQ-030 SHALL reset KEEP_EN and KEEP_VAL to 0.
REQ-031 SHALL, without TRIBUS_KEEPER_EN, omit these ports and all keeper logic; remaining behaviour is identical.

Structure
REQ-032 SHALL take the state enum and the default values of NREQ/DEAD_CYC/MAX_HOLD from shared package tribus_pkg.
REQ-033 SHALL implement owner selection in combinational sub-module tribus_rr_arb (inputs REQ and pointer, outputs one-hot grant and valid).

Verification
REQ-034 SHALL test the single requester: REQ=0001 at cycle 5 -> EN=0001 at cycle 6; REQ drops at 20 -> EN=0 at 21, BUS_IDLE=1, state IDLE at 23.
REQ-035 SHALL test handover: REQ=0011 with owner 0; REQ[0] drops -> EN=0 for exactly 2 cycles, then EN=0010.
REQ-036 SHALL test contention: REQ=1111 held -> owners 0,1,2,3,0, each for 16 cycles, separated by 2 idle cycles; EN never multi-hot.
REQ-037 SHALL test reset mid-OWN: RN low mid-cycle during EN=0100 -> EN=0 before the next edge; after release with REQ=0100, EN=0100 one cycle later.
REQ-038 SHALL test the keeper (TRIBUS_KEEPER_EN): owner drives BUS_IN=1 then releases -> KEEP_EN=1 and KEEP_VAL=1 throughout DEAD and IDLE.
REQ-039 SHALL test DEAD-window pulse: a REQ[2] pulse confined to DEAD -> no grant to 2; state returns to IDLE.
